// File: rtl/alu_pkg.sv
// alu_pkg: shared widths and state encoding for the binary add front-end
package alu_pkg;
  localparam int NIB_W = 4;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LO   = 2'b01,
    ST_HI   = 2'b10
  } state_e;
endpackage

// File: rtl/add4rpl.sv
// add4rpl: 4-bit ripple-carry adder
module add4rpl
  import alu_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic             cin_i,
  output logic [NIB_W-1:0] sum_o,
  output logic             cout_o
);
  logic [NIB_W:0] c;
  always_comb begin
    c[0] = cin_i;
    for (int i = 0; i < NIB_W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end
  assign cout_o = c[NIB_W];
endmodule

// File: rtl/alu_bin_add.sv
// alu_bin_add: nibble-wise binary ADC/SBC with registered sum, half carry, carry, V and Z
module alu_bin_add
  import alu_pkg::*;
#(
  parameter bit SERIAL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              carry_in,
  input  logic              sub,
  input  logic              decimal,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum,
  output logic              half_carry,
  output logic              carry,
  output logic              overflow,
  output logic              zero,
  output logic              sub_o,
  output logic              bcd_en_o
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, res_sum;
  logic [NIB_W-1:0]  lo_q, lo_d, lo_nib;
  logic              cin_q, cin_d, c4_q, c4_d, sub_q, sub_d, bcd_q, bcd_d;
  logic              busy_q, busy_d, done_q, done_d, hc_q, hc_d, co_q, co_d;
  logic              v_q, v_d, z_q, z_d;
  logic              lo_c, res_hc, res_co, take, hi;

  if (SERIAL) begin : g_ser
    // one adder time-shared: low nibble in LO, high nibble in HI
    logic [NIB_W-1:0] s;
    logic             co, lo_ph;
    assign lo_ph = state_q == ST_LO;
    add4rpl u_add (
      .a_i   (lo_ph ? a_q[NIB_W-1:0] : a_q[DATA_W-1:NIB_W]),
      .b_i   (lo_ph ? b_q[NIB_W-1:0] : b_q[DATA_W-1:NIB_W]),
      .cin_i (lo_ph ? cin_q : c4_q),
      .sum_o (s),
      .cout_o(co)
    );
    assign lo_nib  = s;
    assign lo_c    = co;
    assign res_sum = {s, lo_q};
    assign res_hc  = c4_q;
    assign res_co  = co;
  end else begin : g_par
    logic [NIB_W-1:0] ls, hs;
    logic             lc, hc;
    add4rpl u_lo (
      .a_i   (a_q[NIB_W-1:0]),
      .b_i   (b_q[NIB_W-1:0]),
      .cin_i (cin_q),
      .sum_o (ls),
      .cout_o(lc)
    );
    add4rpl u_hi (
      .a_i   (a_q[DATA_W-1:NIB_W]),
      .b_i   (b_q[DATA_W-1:NIB_W]),
      .cin_i (lc),
      .sum_o (hs),
      .cout_o(hc)
    );
    assign lo_nib  = ls;
    assign lo_c    = lc;
    assign res_sum = {hs, ls};
    assign res_hc  = lc;
    assign res_co  = hc;
  end

  always_comb begin
    take    = (state_q == ST_IDLE) & start;
    hi      = state_q == ST_HI;
    state_d = state_q == ST_IDLE ? (start ? (SERIAL ? ST_LO : ST_HI) : ST_IDLE) :
              state_q == ST_LO   ? ST_HI : ST_IDLE;
    a_d     = take ? op_a : a_q;
    b_d     = take ? (sub ? ~op_b : op_b) : b_q;
    cin_d   = take ? carry_in : cin_q;
    sub_d   = take ? sub : sub_q;
    bcd_d   = take ? decimal : bcd_q;
    lo_d    = state_q == ST_LO ? lo_nib : lo_q;
    c4_d    = state_q == ST_LO ? lo_c : c4_q;
    sum_d   = hi ? res_sum : sum_q;
    hc_d    = hi ? res_hc : hc_q;
    co_d    = hi ? res_co : co_q;
    // signed overflow: like-signed operands producing an opposite-signed result
    v_d     = hi ? (a_q[DATA_W-1] == b_q[DATA_W-1]) & (res_sum[DATA_W-1] != a_q[DATA_W-1]) : v_q;
    z_d     = hi ? res_sum == '0 : z_q;
    done_d  = hi;
    busy_d  = state_d != ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      {a_q, b_q, cin_q, sub_q, bcd_q, lo_q, c4_q} <= '0;
      {sum_q, hc_q, co_q, v_q, z_q, done_q, busy_q} <= '0;
    end else begin
      state_q <= state_d;
      {a_q, b_q, cin_q, sub_q, bcd_q, lo_q, c4_q} <= {a_d, b_d, cin_d, sub_d, bcd_d, lo_d, c4_d};
      {sum_q, hc_q, co_q, v_q, z_q, done_q, busy_q} <= {sum_d, hc_d, co_d, v_d, z_d, done_d, busy_d};
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sum        = sum_q;
  assign half_carry = hc_q;
  assign carry      = co_q;
  assign overflow   = v_q;
  assign zero       = z_q;
  assign sub_o      = sub_q;
  assign bcd_en_o   = bcd_q;
endmodule

// File: tb/tb_alu_bin_add.sv
// tb_alu_bin_add: directed scoreboard bench for serial and parallel builds
module tb_alu_bin_add;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, start0 = 1'b0;
  logic [7:0] op_a = '0, op_b = '0;
  logic       carry_in = 1'b0, sub = 1'b0, decimal = 1'b0;
  logic       busy, done, half_carry, carry, overflow, zero, sub_o, bcd_en_o;
  logic [7:0] sum, sum0;
  logic       busy0, done0, half_carry0, carry0, overflow0, zero0, sub_o0, bcd_en_o0;
  bit         sel = 1'b0;
  int         passed = 0, failed = 0;

  typedef struct packed {
    logic [7:0] sum;
    logic hc, c, v, z, sb, bcd;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  alu_bin_add #(.SERIAL(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .carry_in(carry_in), .sub(sub), .decimal(decimal), .busy(busy), .done(done),
    .sum(sum), .half_carry(half_carry), .carry(carry), .overflow(overflow),
    .zero(zero), .sub_o(sub_o), .bcd_en_o(bcd_en_o)
  );

  alu_bin_add #(.SERIAL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .op_a(op_a), .op_b(op_b),
    .carry_in(carry_in), .sub(sub), .decimal(decimal), .busy(busy0), .done(done0),
    .sum(sum0), .half_carry(half_carry0), .carry(carry0), .overflow(overflow0),
    .zero(zero0), .sub_o(sub_o0), .bcd_en_o(bcd_en_o0)
  );

  wire [7:0] o_sum  = sel ? sum0 : sum;
  wire       o_busy = sel ? busy0 : busy;
  wire       o_done = sel ? done0 : done;
  wire       o_hc   = sel ? half_carry0 : half_carry;
  wire       o_c    = sel ? carry0 : carry;
  wire       o_v    = sel ? overflow0 : overflow;
  wire       o_z    = sel ? zero0 : zero;
  wire       o_sb   = sel ? sub_o0 : sub_o;
  wire       o_bcd  = sel ? bcd_en_o0 : bcd_en_o;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] s, input logic hc, c, v, z, sb, bcd);
    q.push_back('{sum: s, hc: hc, c: c, v: v, z: z, sb: sb, bcd: bcd});
  endtask

  function automatic exp_t model(input logic [7:0] a, b, input logic c, s, d);
    logic [7:0] be = s ? ~b : b;
    logic [8:0] t  = {1'b0, a} + {1'b0, be} + {8'd0, c};
    logic [4:0] l  = {1'b0, a[3:0]} + {1'b0, be[3:0]} + {4'd0, c};
    return '{sum: t[7:0], hc: l[4], c: t[8], v: (a[7] == be[7]) && (t[7] != a[7]),
             z: t[7:0] == 8'd0, sb: s, bcd: d};
  endfunction

  task automatic issue(input logic [7:0] a, b, input logic c, s, d);
    op_a = a; op_b = b; carry_in = c; sub = s; decimal = d;
    if (sel) start0 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start0 = 1'b0;
    chk("busy_after_start", {7'd0, o_busy}, 8'd1);
  endtask

  task automatic wait_done(input int lat, input string tag);
    int n = 0;
    exp_t e;
    while (o_done !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 8'(n), 8'(lat));
    chk({tag, "_sb_nonempty"}, {7'd0, q.size() != 0}, 8'd1);
    e = q.size() != 0 ? q.pop_front() : '0;
    chk({tag, "_sum"}, o_sum, e.sum);
    chk({tag, "_hc"}, {7'd0, o_hc}, {7'd0, e.hc});
    chk({tag, "_carry"}, {7'd0, o_c}, {7'd0, e.c});
    chk({tag, "_v"}, {7'd0, o_v}, {7'd0, e.v});
    chk({tag, "_z"}, {7'd0, o_z}, {7'd0, e.z});
    chk({tag, "_sub_o"}, {7'd0, o_sb}, {7'd0, e.sb});
    chk({tag, "_bcd_en"}, {7'd0, o_bcd}, {7'd0, e.bcd});
    chk({tag, "_busy_in_done"}, {7'd0, o_busy}, 8'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_outs"}, {o_sum}, 8'd0);
    chk({tag, "_flags"}, {1'b0, o_busy, o_done, o_hc, o_c, o_v, o_z, o_sb}, 8'd0);
    chk({tag, "_bcd"}, {7'd0, o_bcd}, 8'd0);
  endtask

  initial begin
    int dones;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_zero("reset");

    push(8'h3C, 0, 0, 0, 0, 0, 1);
    issue(8'h15, 8'h27, 0, 0, 1);
    wait_done(2, "adc_dec");

    push(8'h4F, 0, 1, 0, 0, 1, 1);
    issue(8'h50, 8'h01, 1, 1, 1);
    wait_done(2, "sbc_dec");

    push(8'hA0, 0, 0, 1, 0, 0, 0);
    issue(8'h50, 8'h50, 0, 0, 0);
    wait_done(2, "ovf");

    push(8'h00, 1, 1, 0, 1, 0, 0);
    issue(8'hFF, 8'h01, 0, 0, 0);
    wait_done(2, "wrap_zero");

    push(8'h02, 0, 0, 0, 0, 0, 0);
    issue(8'h01, 8'h01, 0, 0, 0);
    op_a = 8'h10; op_b = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, "busy_ignore");
    push(8'h42, 0, 0, 0, 0, 0, 0);
    issue(8'h20, 8'h22, 0, 0, 0);
    wait_done(2, "back_to_back");
    @(negedge clk);
    chk("single_done", {7'd0, o_done}, 8'd0);

    issue(8'h58, 8'h46, 1, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_zero("abort");
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      dones += int'(o_done);
    end
    chk("abort_no_done", 8'(dones), 8'd0);
    push(8'h9F, 0, 0, 1, 0, 0, 0);
    issue(8'h58, 8'h46, 1, 0, 0);
    wait_done(2, "after_abort");

    for (int i = 0; i < 6; i++) begin
      logic [7:0] a, b;
      logic c, s, d;
      a = 8'($urandom); b = 8'($urandom);
      c = 1'($urandom); s = 1'($urandom); d = 1'($urandom);
      q.push_back(model(a, b, c, s, d));
      issue(a, b, c, s, d);
      wait_done(2, "rand");
    end

    sel = 1'b1;
    push(8'h3C, 0, 0, 0, 0, 0, 1);
    issue(8'h15, 8'h27, 0, 0, 1);
    wait_done(1, "par_adc_dec");
    push(8'h4F, 0, 1, 0, 0, 1, 1);
    issue(8'h50, 8'h01, 1, 1, 1);
    wait_done(1, "par_sbc_dec");

    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end
endmodule

// File: doc/alu_bin_add.md
Name: alu_bin_add

Overview:
- Binary add/subtract front-end for the m6502 decimal datapath.
- Accepts ADC/SBC operands, computes an 8-bit binary sum nibble by nibble, and registers the sum, half carry and carry.
- Those outputs feed bcd_adj directly: sum→datai, half_carry→cin4, carry→cin8, sub_o→sub, bcd_en_o→bcd_en.
- Also produces binary V and Z flags for the status register.

Parameters:
- SERIAL, 1, 1 = nibble-serial, one shared add4rpl, latency 3; 0 = two chained add4rpl, latency 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  operation request; sampled only when busy=0
- op_a  in  8  accumulator operand
- op_b  in  8  memory operand
- carry_in  in  1  processor C flag
- sub  in  1  1=SBC (A + ~B + C), 0=ADC (A + B + C)
- decimal  in  1  processor D flag
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; result outputs valid from this cycle
- sum  out  8  binary sum (to bcd_adj datai)
- half_carry  out  1  carry out of bit 3 (to cin4)
- carry  out  1  carry out of bit 7 (to cin8)
- overflow  out  1  binary signed overflow V
- zero  out  1  binary sum == 0
- sub_o  out  1  latched sub (to bcd_adj sub)
- bcd_en_o  out  1  latched decimal (to bcd_adj bcd_en)

Behaviour:
- All outputs are registered. Reset values: every output 0; state IDLE.
- Reset mid-operation aborts immediately. No done is issued, and the partial result is discarded.
- Start acceptance: start is accepted when state=IDLE and reset=0.
- On acceptance, latch op_a, b_eff = sub ? ~op_b : op_b, carry_in, sub, decimal.
- sub_o and bcd_en_o update at acceptance and hold until the next acceptance.
- State machine, SERIAL=1:
  - IDLE→LO on accepted start. busy=1 from the next cycle.
  - LO: shared adder gets a=A[3:0], b=b_eff[3:0], cin=carry_in. Register lo_sum and c4. Go to HI.
  - HI: shared adder gets a=A[7:4], b=b_eff[7:4], cin=c4. Register sum={hi,lo_sum}, half_carry=c4, carry=cout. Compute overflow and zero from the final sum. Pulse done. busy=0. Go to IDLE.
- State machine, SERIAL=0: state LO is skipped and both nibbles are computed in one cycle (IDLE→HI→IDLE).
- Latency: start sampled at edge k → done=1 in the cycle after edge k+2 (SERIAL=1) or k+1 (SERIAL=0).
- Overflow formula: overflow = (A[7] == b_eff[7]) & (sum[7] != A[7]).
- Width rules: all arithmetic is modulo 2^8. Carry-out is the only overflow indication; no saturation.
- Back-to-back: start asserted in the done cycle is accepted, since state is IDLE. Throughput is one op per 3 cycles (SERIAL=1).
- Start while busy is ignored, with no queuing. Operands are not re-sampled.
- Result outputs (sum, flags) hold between done pulses and change only in the HI cycle.
- Input changes while busy have no effect on the result.
- Decimal adjustment is not performed here. decimal only passes through to bcd_en_o.
- The V/Z semantics in decimal mode are the binary ones. This matches NMOS 6502 behaviour.

Decomposition:
- Shared package alu_pkg holds:
  - state encoding constants ST_IDLE=2'b00, ST_LO=2'b01, ST_HI=2'b10;
  - NIB_W=4 and DATA_W=8.
- Sub-module: the existing add4rpl.
  - SERIAL=1: one instance, time-shared through a nibble operand mux.
  - SERIAL=0: two instances chained via carry.
- bcd_adj stays a separate downstream instance at the top level. It is not embedded here.

Test Plan:
- ADC decimal: op_a=0x15, op_b=0x27, carry_in=0, sub=0, decimal=1 → done 3 cycles after start; sum=0x3C, half_carry=0, carry=0, V=0, Z=0, bcd_en_o=1. Downstream bcd_adj yields 0x42.
- SBC decimal: op_a=0x50, op_b=0x01, carry_in=1, sub=1, decimal=1 → sum=0x4F, half_carry=0, carry=1, sub_o=1. Downstream bcd_adj yields 0x49, cout=1.
- Binary overflow: op_a=0x50, op_b=0x50, carry_in=0, sub=0 → sum=0xA0, carry=0, V=1, Z=0. Also op_a=0xFF, op_b=0x01 → sum=0x00, half_carry=1, carry=1, Z=1, V=0.
- Busy ignore and back-to-back: start 0x01+0x01, then start 0x10+0x10 one cycle later → single done, sum=0x02. A third start in the done cycle with 0x20+0x22 is accepted → sum=0x42 three cycles later.
- Reset mid-operation: start 0x58+0x46 carry_in=1, assert reset in the LO cycle → no done pulse; all outputs 0. A new start 0x58+0x46 carry_in=1 → sum=0x9F, half_carry=0, carry=0.
- SERIAL=0 build: repeat the first scenario → done 2 cycles after start, identical values.
